// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit: EX-stage ALU control decode plus optional iterative mul/div unit enabled by EXEC_CTRL_MULDIV_EN
module exec_ctrl_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [3:0]      alu_op,
  input  logic [4:0]      funct,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      alu_cntl,
  output logic            mdu_busy,
  output logic            mdu_valid,
  output logic [XLEN-1:0] mdu_result
);
  logic [2:0] f3;
  logic [3:0] rv_cntl;
  assign f3 = funct[2:0];
  // RV32I funct3 decode shared by OP-IMM and OP, then per-class overrides
  always_comb begin
    rv_cntl = f3 == 3'b000 ? 4'b0110 :
              f3 == 3'b001 ? 4'b0011 :
              f3 == 3'b010 ? 4'b1000 :
              f3 == 3'b011 ? 4'b1001 :
              f3 == 3'b100 ? 4'b0010 :
              f3 == 3'b101 ? (funct[3] ? 4'b0101 : 4'b0100) :
              f3 == 3'b110 ? 4'b0001 : 4'b0000;
    alu_cntl = (alu_op == 4'b0000 || alu_op == 4'b0010) ? 4'b0110 :
               alu_op == 4'b0011 ? (f3 < 3'b011 ? 4'b0110 : 4'b1111) :
               alu_op == 4'b0001 ? ((f3 == 3'b001 && funct[3]) ? 4'b1111 : rv_cntl) :
               alu_op == 4'b0100 ? (funct[4] ? 4'b1111 : (f3 == 3'b000 && funct[3]) ? 4'b0111 : rv_cntl) :
               4'b1111;
  end
`ifdef EXEC_CTRL_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam int CW = $clog2(XLEN);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   m, mag_a, mag_b, q_s, r_s;
  logic [2*XLEN-1:0] p, p_nx, prod;
  logic [XLEN:0]     sum, diff;
  logic [2:0]        f3_q;
  logic              sa, sb, na, nb, accept, last;
  assign accept   = state == IDLE && valid_in && !flush && alu_op == 4'b0100 && funct[4];
  assign na       = op_a[XLEN-1] && f3 != 3'b011 && f3 != 3'b101 && f3 != 3'b111;
  assign nb       = op_b[XLEN-1] && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110);
  assign mag_a    = na ? -op_a : op_a;
  assign mag_b    = nb ? -op_b : op_b;
  assign last     = cnt == CW'(XLEN - 1);
  assign mdu_busy = accept || state == MUL || state == DIV;
  // one shift-add (MUL) or restoring-subtract (DIV) step on {hi, lo}, plus sign fix-up of the final value
  always_comb begin
    sum  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
    diff = {p[2*XLEN-1:XLEN], p[XLEN-1]} - {1'b0, m};
    p_nx = state == MUL ? {sum, p[XLEN-1:1]} :
           {diff[XLEN] ? {p[2*XLEN-2:XLEN], p[XLEN-1]} : diff[XLEN-1:0], p[XLEN-2:0], ~diff[XLEN]};
    prod = (sa ^ sb) ? -p_nx : p_nx;
    q_s  = (sa ^ sb) ? -p_nx[XLEN-1:0] : p_nx[XLEN-1:0];
    r_s  = sa ? -p_nx[2*XLEN-1:XLEN] : p_nx[2*XLEN-1:XLEN];
  end
  // FSM: accept, iterate XLEN steps, publish the result with a one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      m          <= '0;
      p          <= '0;
      f3_q       <= '0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      mdu_valid  <= 1'b0;
      mdu_result <= '0;
    end else begin
      mdu_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            f3_q <= f3;
            sa   <= na;
            sb   <= nb;
            cnt  <= '0;
            if (!f3[2]) begin
              state <= MUL;
              m     <= mag_a;
              p     <= {{XLEN{1'b0}}, mag_b};
            end else if (op_b != '0) begin
              state <= DIV;
              m     <= mag_b;
              p     <= {{XLEN{1'b0}}, mag_a};
            end else begin
              state      <= DONE;
              mdu_valid  <= 1'b1;
              mdu_result <= f3[1] ? op_a : '1;
            end
          end
          MUL, DIV: begin
            p   <= p_nx;
            cnt <= cnt + CW'(1);
            if (last) begin
              state      <= DONE;
              mdu_valid  <= 1'b1;
              mdu_result <= state == DIV ? (f3_q[1] ? r_s : q_s) :
                            f3_q == 3'b000 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`else
  logic unused;
  assign unused     = ^{clk, rst_n, valid_in, flush, op_a, op_b};
  assign mdu_busy   = 1'b0;
  assign mdu_valid  = 1'b0;
  assign mdu_result = '0;
`endif
endmodule

// File: doc/exec_ctrl_unit.md
EXEC_CTRL_UNIT -- requirements
Module: exec_ctrl_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port valid_in  input  1  an instruction is present in EX this cycle.
REQ-005 SHALL have port flush  input  1  discard the in-flight operation.
REQ-006 SHALL have port alu_op  input  4  instruction class: 0000 load, 0001 OP-IMM, 0010 AUIPC, 0011 store, 0100 OP.
REQ-007 SHALL have port funct  input  5  funct[2:0]=funct3, funct[3]=funct7[5], funct[4]=funct7[0] (M-extension select).
REQ-008 SHALL have ports op_a, op_b  input  XLEN each  source operands.
REQ-009 SHALL have port alu_cntl  output  4  ALU operation code.
REQ-010 SHALL have port mdu_busy  output  1  pipeline stall request.
REQ-011 SHALL have port mdu_valid  output  1  one-cycle pulse, mdu_result valid.
REQ-012 SHALL have port mdu_result  output  XLEN  multiply/divide result.

Function
REQ-013 SHALL drive alu_cntl combinationally: AND 0000, OR 0001, XOR 0010, SLL 0011, SRL 0100, SRA 0101, ADD 0110, SUB 0111, SLT 1000, SLTU 1001, undefined combinations 1111.
REQ-014 SHALL map load, AUIPC and store (funct3 000/001/010) to ADD; OP-IMM and OP by funct3 as RV32I; SUB only for OP with funct[3]=1; SLTI/SLT to SLT, SLTIU/SLTU to SLTU; SLLI with funct[3]=1 and store with any other funct3 to 1111.
REQ-015 SHALL treat alu_op=0100 with funct[4]=1 as an MDU op (funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU), with alu_cntl=1111.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-017 SHALL accept an MDU op only in IDLE with valid_in=1 and flush=0, latching operands, funct3 and operand signs; valid_in is ignored in all other states.
REQ-018 SHALL go IDLE->MUL for MUL*, IDLE->DIV for DIV/REM with op_b nonzero, and IDLE->DONE for op_b=0.
REQ-019 SHALL multiply by shift-add on magnitudes, one bit per cycle, XLEN cycles in MUL, forming a 2*XLEN product with sign fixed at exit; MUL returns the low half, MULH/MULHSU/MULHU the high half.
REQ-020 SHALL divide by restoring division on magnitudes, one bit per cycle, XLEN cycles in DIV; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 SHALL on divide by zero return quotient all-ones and remainder op_a.
REQ-022 SHALL on signed overflow (op_a = most-negative, op_b = -1) return quotient op_a and remainder 0.
REQ-023 SHALL hold mdu_busy=1 combinationally in the accept cycle and in MUL and DIV, and 0 in DONE and IDLE.
REQ-024 SHALL pulse mdu_valid for exactly one cycle in DONE, then return to IDLE; latency from accept to mdu_valid is XLEN+1 cycles, or 1 cycle for divide by zero.
REQ-025 SHALL hold mdu_result at the last result until the next DONE.
REQ-026 SHALL on flush=1 return to IDLE on the next edge from any state with no mdu_valid; flush wins over simultaneous acceptance.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, mdu_busy=0, mdu_valid=0, mdu_result=0 and clear the iteration counter and operand registers.
REQ-028 SHALL abort an operation in progress when reset is asserted mid-operation, without producing mdu_valid after release.

Configuration
REQ-029 SHALL with macro EXEC_CTRL_MULDIV_EN defined include the MDU and FSM per REQ-015..REQ-026.
REQ-030 SHALL with EXEC_CTRL_MULDIV_EN undefined decode funct[4]=1 OP as 1111 and tie mdu_busy, mdu_valid and mdu_result to 0, with no MDU state elements.

Verification
REQ-031 SHALL cover decode sweep of all alu_op x funct: OP funct=01000 -> alu_cntl 0111; OP-IMM funct=00011 -> 1001; store funct3=011 -> 1111.
REQ-032 SHALL cover XLEN=32 MUL 7 x -3 -> mdu_valid 33 cycles after accept, mdu_result 0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 SHALL cover DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-034 SHALL cover DIV 5/0 -> 0xFFFFFFFF after 1 cycle; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-035 SHALL cover flush at cycle 10 of DIV -> IDLE next cycle, no mdu_valid; a second valid_in during busy is ignored.
REQ-036 SHALL cover rst_n low mid-MUL -> outputs 0 immediately; after release a new MUL 3x4 -> 12.
